// File: rtl/btn_conditioner.sv
// btn_conditioner: push-button front end for the RGB LED driver.
// Synchronises the raw pin, debounces press and release, times the hold
// and produces a clean level plus press/release/long-press pulses and a
// press-toggle flag.
// Optional feature: define BTN_REPEAT_EN to enable auto-repeat of btn_press
// after a long press.
module btn_conditioner #(
  parameter int ACTIVE_HIGH   = 1,
  parameter int DEB_CYCLES    = 1000000,
  parameter int DEB_W         = 20,
  parameter int LONG_CYCLES   = 100000000,
  parameter int LONG_W        = 27,
  parameter int REPEAT_CYCLES = 20000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic btn_toggle
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    HELD         = 3'd2,
    RELEASE_WAIT = 3'd3
  } state_t;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_PRE  = LONG_W'(LONG_CYCLES - 2);

  // Reject configurations the counters cannot represent.
  generate
    if (DEB_CYCLES < 2 || LONG_CYCLES < 2 || REPEAT_CYCLES < 1 ||
        DEB_W < $clog2(DEB_CYCLES + 1) || LONG_W < $clog2(LONG_CYCLES + 1)) begin : g_param_check
      $error("btn_conditioner: invalid parameter set");
    end
  endgenerate

  // Hold counter increments but parks at the long-press threshold, so the
  // long pulse can only ever be generated once per press.
  function automatic logic [LONG_W-1:0] hold_sat_inc(input logic [LONG_W-1:0] v);
    return (v == LONG_LAST) ? v : v + LONG_W'(1);
  endfunction

  function automatic logic [DEB_W-1:0] deb_inc(input logic [DEB_W-1:0] v);
    return v + DEB_W'(1);
  endfunction

  logic pin_pol;
  logic sync_p0, sync_p1;
  logic s;

  state_t            state_q, state_d;
  logic [DEB_W-1:0]  dcnt_q, dcnt_d;
  logic [LONG_W-1:0] hcnt_q, hcnt_d;
  logic              level_d, press_d, release_d, long_d, toggle_d;

`ifdef BTN_REPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rcnt_q, rcnt_d;
`endif

  // Polarity is normalised before the synchroniser so everything downstream sees 1 = pressed.
  assign pin_pol = (ACTIVE_HIGH != 0) ? btn_raw : ~btn_raw;
  assign s       = sync_p1;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pin_pol;
      sync_p1 <= sync_p0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q      <= '0;
      hcnt_q      <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
      btn_toggle  <= 1'b0;
    end else begin
      dcnt_q      <= dcnt_d;
      hcnt_q      <= hcnt_d;
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      btn_long    <= long_d;
      btn_toggle  <= toggle_d;
    end
  end

`ifdef BTN_REPEAT_EN
  // Auto-repeat period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q <= '0;
    end else begin
      rcnt_q <= rcnt_d;
    end
  end
`endif

  // Next-state, counter and output decode.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    hcnt_d    = hcnt_q;
    level_d   = btn_level;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
`ifdef BTN_REPEAT_EN
    rcnt_d    = rcnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          dcnt_d  = '0;
        end
      end

      PRESS_WAIT: begin
        if (!s) begin
          // Glitch: drop back without any output, qualification restarts from scratch.
          state_d = IDLE;
        end else if (dcnt_q == DEB_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          press_d = 1'b1;
          hcnt_d  = '0;
`ifdef BTN_REPEAT_EN
          rcnt_d  = '0;
`endif
        end else begin
          dcnt_d = deb_inc(dcnt_q);
        end
      end

      HELD: begin
        hcnt_d = hold_sat_inc(hcnt_q);
        long_d = (hcnt_q == LONG_PRE);
`ifdef BTN_REPEAT_EN
        // Repeats only start once the hold counter has parked, i.e. after btn_long.
        if (hcnt_q == LONG_LAST) begin
          if (rcnt_q == REP_LAST) begin
            press_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + REP_W'(1);
          end
        end
`endif
        if (!s) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = '0;
        end
      end

      RELEASE_WAIT: begin
        // Hold time keeps running: a bouncy release still counts as held.
        hcnt_d = hold_sat_inc(hcnt_q);
        long_d = (hcnt_q == LONG_PRE);
        if (s) begin
          state_d = HELD;
        end else if (dcnt_q == DEB_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
`ifdef BTN_REPEAT_EN
          rcnt_d    = '0;
`endif
        end else begin
          dcnt_d = deb_inc(dcnt_q);
        end
      end

      default: begin
        // Corrupted encoding: recover to IDLE and drop the level.
        state_d = IDLE;
        level_d = 1'b0;
`ifdef BTN_REPEAT_EN
        rcnt_d  = '0;
`endif
      end
    endcase

    toggle_d = btn_toggle ^ press_d;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner (DEB_CYCLES=8, LONG_CYCLES=40,
// REPEAT_CYCLES=10, ACTIVE_HIGH=1). Stimulus pushes expected pulse events
// (kind, edge count, level, toggle) into a queue; a monitor pops and
// compares whenever the DUT pulses.
module tb_btn_conditioner;

  localparam int DEB  = 8;
  localparam int LONG = 40;
  localparam int REP  = 10;

  localparam int K_PRESS   = 0;
  localparam int K_LONG    = 1;
  localparam int K_RELEASE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_raw = 1'b0;
  logic btn_level, btn_press, btn_release, btn_long, btn_toggle;

  typedef struct {
    int   kind;
    int   t;
    logic lvl;
    logic tog;
  } exp_t;

  exp_t expq[$];
  int   edge_n = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic exp_tog = 1'b0;
  int   t0;

  btn_conditioner #(
    .ACTIVE_HIGH  (1),
    .DEB_CYCLES   (DEB),
    .DEB_W        (4),
    .LONG_CYCLES  (LONG),
    .LONG_W       (6),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .btn_toggle (btn_toggle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, edge_n);
  endtask

  // Queue an expected event; press events flip the modelled toggle.
  task automatic push(input int k, input int t, input logic lvl);
    exp_t e;
    if (k == K_PRESS) exp_tog = ~exp_tog;
    e.kind = k;
    e.t    = t;
    e.lvl  = lvl;
    e.tog  = exp_tog;
    expq.push_back(e);
  endtask

  task automatic see(input int k);
    exp_t e;
    if (expq.size() == 0) begin
      chk("unexpected_event_kind", k, -1);
    end else begin
      e = expq.pop_front();
      chk("evt_kind", k, e.kind);
      chk("evt_time", edge_n, e.t);
      chk("evt_level", int'(btn_level), int'(e.lvl));
      chk("evt_toggle", int'(btn_toggle), int'(e.tog));
    end
  endtask

  // Monitor: sample away from the active edge and score every pulse.
  always @(negedge clk) begin
    if (btn_press)   see(K_PRESS);
    if (btn_long)    see(K_LONG);
    if (btn_release) see(K_RELEASE);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"},   int'(btn_level),   0);
    chk({tag, "_press"},   int'(btn_press),   0);
    chk({tag, "_release"}, int'(btn_release), 0);
    chk({tag, "_long"},    int'(btn_long),    0);
    chk({tag, "_toggle"},  int'(btn_toggle),  0);
  endtask

  initial begin
    // Reset state.
    wait_cyc(3);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(5);

    // Clean press held 20 cycles.
    btn_raw = 1'b1;
    t0 = edge_n + 1;
    push(K_PRESS,   t0 + DEB + 2, 1'b1);
    push(K_RELEASE, t0 + 20 + DEB + 2, 1'b0);
    wait_cyc(20);
    btn_raw = 1'b0;
    wait_cyc(40);

    // Bouncing press 1,0,1 with 3-cycle pulses, then stable.
    btn_raw = 1'b1;
    wait_cyc(3);
    btn_raw = 1'b0;
    wait_cyc(3);
    btn_raw = 1'b1;
    t0 = edge_n + 1;
    push(K_PRESS,   t0 + 10, 1'b1);
    push(K_RELEASE, t0 + 25, 1'b0);
    wait_cyc(15);
    btn_raw = 1'b0;
    wait_cyc(40);

    // 5-cycle glitch alone: nothing expected.
    btn_raw = 1'b1;
    wait_cyc(5);
    btn_raw = 1'b0;
    wait_cyc(30);

    // Long hold: 60 cycles past accept.
    btn_raw = 1'b1;
    t0 = edge_n + 1;
    push(K_PRESS, t0 + 10, 1'b1);
    push(K_LONG,  t0 + 49, 1'b1);
`ifdef BTN_REPEAT_EN
    push(K_PRESS, t0 + 59, 1'b1);
    push(K_PRESS, t0 + 69, 1'b1);
`endif
    push(K_RELEASE, t0 + 80, 1'b0);
    wait_cyc(70);
    btn_raw = 1'b0;
    wait_cyc(40);

    // Release bounce: 4 cycles low, back high, then real release.
    btn_raw = 1'b1;
    t0 = edge_n + 1;
    push(K_PRESS,   t0 + 10, 1'b1);
    push(K_RELEASE, t0 + 44, 1'b0);
    wait_cyc(20);
    btn_raw = 1'b0;
    wait_cyc(4);
    btn_raw = 1'b1;
    wait_cyc(10);
    chk("bounce_level_held", int'(btn_level), 1);
    btn_raw = 1'b0;
    wait_cyc(40);

    // Reset mid-HELD with the pin still held.
    btn_raw = 1'b1;
    t0 = edge_n + 1;
    push(K_PRESS, t0 + 10, 1'b1);
    wait_cyc(20);
    chk("pre_reset_level", int'(btn_level), 1);
    rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    exp_tog = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    t0 = edge_n + 1;
    push(K_PRESS,   t0 + 10, 1'b1);
    push(K_RELEASE, t0 + 25, 1'b0);
    wait_cyc(15);
    btn_raw = 1'b0;
    wait_cyc(40);

`ifdef BTN_REPEAT_EN
    // Auto-repeat: long at 40, repeats at 50, 60, 70, 80 hold cycles.
    btn_raw = 1'b1;
    t0 = edge_n + 1;
    push(K_PRESS,   t0 + 10, 1'b1);
    push(K_LONG,    t0 + 49, 1'b1);
    push(K_PRESS,   t0 + 59, 1'b1);
    push(K_PRESS,   t0 + 69, 1'b1);
    push(K_PRESS,   t0 + 79, 1'b1);
    push(K_PRESS,   t0 + 89, 1'b1);
    push(K_RELEASE, t0 + 100, 1'b0);
    wait_cyc(90);
    btn_raw = 1'b0;
    wait_cyc(40);
`endif

    wait_cyc(5);
    chk("pending_events", expq.size(), 0);
    chk("final_level", int'(btn_level), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
